// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared encodings and defaults for the SRAM bus arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam int DEFAULT_WAIT_CYCLES    = 2;
    localparam int DEFAULT_ADDR_W         = 20;
    localparam int DEFAULT_MEM_STREAK_MAX = 4;

    // Byte address to word index; the caller keeps as many low bits as the SRAM needs.
    function automatic logic [31:0] word_of(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one single-ported SRAM between instruction fetch and the MEM stage
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES    = DEFAULT_WAIT_CYCLES,
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int MEM_STREAK_MAX = DEFAULT_MEM_STREAK_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_be,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              sram_en,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    // cnt only has to hold WAIT_CYCLES-1; keep at least one bit for WAIT_CYCLES == 1.
    localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int STREAK_W = $clog2(MEM_STREAK_MAX + 1);
    localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(MEM_STREAK_MAX);

    state_t              state;
    owner_t              owner;
    logic [CNT_W-1:0]    cnt;
    logic [STREAK_W-1:0] streak;
    logic [31:0]         rdata_q;

    logic [31:0] if_word;
    logic [31:0] mem_word;
    logic        grant_if;
    logic        grant_mem;
    logic        unused_addr_bits;

    assign if_word  = word_of(if_addr);
    assign mem_word = word_of(mem_addr);

    // Byte-lane bits and address bits above the SRAM window are intentionally dropped.
    assign unused_addr_bits = ^{if_word, mem_word};

    assign if_rdata  = rdata_q;
    assign mem_rdata = rdata_q;

    // A side stalls while it is asking and its access has not yet completed.
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = mem_req & ~mem_done;

    // Arbitration in IDLE: MEM wins unless IF has already been passed over MEM_STREAK_MAX times.
    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (state == ST_IDLE) begin
            if (mem_req && !(if_req && (streak == STREAK_SAT))) begin
                grant_mem = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    // Transaction sequencer: grant, hold the SRAM pins for WAIT_CYCLES, then pulse the owner's done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_IF;
            cnt        <= '0;
            streak     <= '0;
            rdata_q    <= '0;
            if_done    <= 1'b0;
            mem_done   <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_be    <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_mem) begin
                        state      <= ST_BUSY;
                        owner      <= OWN_MEM;
                        cnt        <= CNT_LOAD;
                        sram_en    <= 1'b1;
                        sram_we    <= mem_we;
                        sram_be    <= mem_be;
                        sram_addr  <= mem_word[ADDR_W-1:0];
                        sram_wdata <= mem_wdata;
                        if (!if_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_SAT) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (grant_if) begin
                        state     <= ST_BUSY;
                        owner     <= OWN_IF;
                        cnt       <= CNT_LOAD;
                        sram_en   <= 1'b1;
                        sram_we   <= 1'b0;
                        sram_be   <= 4'b1111;
                        sram_addr <= if_word[ADDR_W-1:0];
                        streak    <= '0;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // sram_we still tells us whether this access was a read.
                        if (!sram_we) begin
                            rdata_q <= sram_rdata;
                        end
                        sram_en <= 1'b0;
                        sram_we <= 1'b0;
                        state   <= ST_DONE;
                        if (owner == OWN_MEM) begin
                            mem_done <= 1'b1;
                        end else begin
                            if_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for the SRAM bus arbiter
module tb_mem_bus_arbiter;

    localparam int W    = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
    logic [3:0]  mem_be;
    logic        if_done, mem_done, stall_if, stall_mem, sram_en, sram_we;
    logic [31:0] if_rdata, mem_rdata, sram_wdata;
    logic [3:0]  sram_be;
    logic [19:0] sram_addr;

    logic        b_if_req, b_mem_req, b_mem_we;
    logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata, b_sram_rdata;
    logic [3:0]  b_mem_be;
    logic        b_if_done, b_mem_done, b_stall_if, b_stall_mem, b_sram_en, b_sram_we;
    logic [31:0] b_if_rdata, b_mem_rdata, b_sram_wdata;
    logic [3:0]  b_sram_be;
    logic [19:0] b_sram_addr;

    mem_bus_arbiter #(.WAIT_CYCLES(W), .ADDR_W(20), .MEM_STREAK_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .sram_en(sram_en), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(1), .ADDR_W(20), .MEM_STREAK_MAX(SMAX)) dut_w1 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_done(b_if_done), .if_rdata(b_if_rdata),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_done(b_mem_done), .mem_rdata(b_mem_rdata),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem),
        .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_be(b_sram_be), .sram_addr(b_sram_addr),
        .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ctl = {if_req, mem_req, mem_we}; flg = {sram_en, sram_we, if_done, mem_done, stall_if, stall_mem}
    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] rd;
        logic [5:0]  flg;
        logic [3:0]  be;
        logic [19:0] addr;
        logic [31:0] wd;
        logic [31:0] rq;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mkv(input logic [2:0] ctl, input logic [31:0] rd, input logic [5:0] flg,
                                 input logic [3:0] be, input logic [19:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rq);
        vec_t v;
        v.ctl = ctl; v.rd = rd; v.flg = flg; v.be = be; v.addr = addr; v.wd = wd; v.rq = rq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic en, input logic we, input logic [3:0] be,
                           input logic [19:0] addr, input logic [31:0] wd);
        chk({tag, " sram_en"},    32'(sram_en),    32'(en));
        chk({tag, " sram_we"},    32'(sram_we),    32'(we));
        chk({tag, " sram_be"},    32'(sram_be),    32'(be));
        chk({tag, " sram_addr"},  32'(sram_addr),  32'(addr));
        chk({tag, " sram_wdata"}, sram_wdata,      wd);
    endtask

    // Reference-model state for the randomized phase
    logic        ip, mp, mwe, gwe;
    logic [31:0] ia, ma, mwd, rv, e_wd, e_rq;
    logic [3:0]  mbe, e_be;
    logic [19:0] e_addr;
    int          streak_m, win, n;
    logic [1:0]  seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mkv(3'b101, 32'h0,        6'b000010, 4'h0, 20'h00, 32'h0,        32'h0);
        tbl[1]  = mkv(3'b101, 32'h0,        6'b100010, 4'hF, 20'h40, 32'h0,        32'h0);
        tbl[2]  = mkv(3'b101, 32'hDEADBEEF, 6'b100010, 4'hF, 20'h40, 32'h0,        32'h0);
        tbl[3]  = mkv(3'b101, 32'h0,        6'b001000, 4'hF, 20'h40, 32'h0,        32'hDEADBEEF);
        tbl[4]  = mkv(3'b111, 32'h0,        6'b000011, 4'hF, 20'h40, 32'h0,        32'hDEADBEEF);
        tbl[5]  = mkv(3'b111, 32'h0,        6'b110011, 4'h3, 20'h04, 32'h12345678, 32'hDEADBEEF);
        tbl[6]  = mkv(3'b111, 32'h0BADF00D, 6'b110011, 4'h3, 20'h04, 32'h12345678, 32'hDEADBEEF);
        tbl[7]  = mkv(3'b111, 32'h0,        6'b000110, 4'h3, 20'h04, 32'h12345678, 32'hDEADBEEF);
        tbl[8]  = mkv(3'b101, 32'h0,        6'b000010, 4'h3, 20'h04, 32'h12345678, 32'hDEADBEEF);
        tbl[9]  = mkv(3'b101, 32'h0,        6'b100010, 4'hF, 20'h40, 32'h12345678, 32'hDEADBEEF);
        tbl[10] = mkv(3'b101, 32'hCAFEF00D, 6'b100010, 4'hF, 20'h40, 32'h12345678, 32'hDEADBEEF);
        tbl[11] = mkv(3'b101, 32'h0,        6'b001000, 4'hF, 20'h40, 32'h12345678, 32'hCAFEF00D);
        tbl[12] = mkv(3'b010, 32'h0,        6'b000001, 4'hF, 20'h40, 32'h12345678, 32'hCAFEF00D);
        tbl[13] = mkv(3'b010, 32'h0,        6'b100001, 4'h3, 20'h04, 32'h12345678, 32'hCAFEF00D);
        tbl[14] = mkv(3'b010, 32'hAAAA5555, 6'b100001, 4'h3, 20'h04, 32'h12345678, 32'hCAFEF00D);
        tbl[15] = mkv(3'b010, 32'h0,        6'b000100, 4'h3, 20'h04, 32'h12345678, 32'hAAAA5555);
        tbl[16] = mkv(3'b011, 32'h0,        6'b000001, 4'h3, 20'h04, 32'h12345678, 32'hAAAA5555);
        tbl[17] = mkv(3'b011, 32'h0,        6'b110001, 4'h3, 20'h04, 32'h12345678, 32'hAAAA5555);
        tbl[18] = mkv(3'b011, 32'h11111111, 6'b110001, 4'h3, 20'h04, 32'h12345678, 32'hAAAA5555);
        tbl[19] = mkv(3'b011, 32'h0,        6'b000100, 4'h3, 20'h04, 32'h12345678, 32'hAAAA5555);
        tbl[20] = mkv(3'b001, 32'h0,        6'b000000, 4'h3, 20'h04, 32'h12345678, 32'hAAAA5555);

        rst = 1'b1;
        if_req = 0; mem_req = 0; mem_we = 0; mem_be = 4'h3;
        if_addr = 32'h0000_0100; mem_addr = 32'h0000_0010; mem_wdata = 32'h12345678; sram_rdata = 0;
        b_if_req = 0; b_mem_req = 0; b_mem_we = 0; b_mem_be = 4'hF;
        b_if_addr = 0; b_mem_addr = 0; b_mem_wdata = 0; b_sram_rdata = 0;
        step();
        step();
        rst = 1'b0;

        // Directed timeline: IF read, MEM-vs-IF conflict, load then store
        for (int i = 0; i < 21; i++) begin
            {if_req, mem_req, mem_we} = tbl[i].ctl;
            sram_rdata = tbl[i].rd;
            #1;
            chk_bus($sformatf("tbl%0d", i), tbl[i].flg[5], tbl[i].flg[4], tbl[i].be, tbl[i].addr, tbl[i].wd);
            chk($sformatf("tbl%0d if_done", i),   32'(if_done),   32'(tbl[i].flg[3]));
            chk($sformatf("tbl%0d mem_done", i),  32'(mem_done),  32'(tbl[i].flg[2]));
            chk($sformatf("tbl%0d stall_if", i),  32'(stall_if),  32'(tbl[i].flg[1]));
            chk($sformatf("tbl%0d stall_mem", i), 32'(stall_mem), 32'(tbl[i].flg[0]));
            chk($sformatf("tbl%0d if_rdata", i),  if_rdata,       tbl[i].rq);
            chk($sformatf("tbl%0d mem_rdata", i), mem_rdata,      tbl[i].rq);
            step();
        end

        // Starvation bound: both held high gives MEM x4, IF x1, then MEM again
        if_req = 1; mem_req = 1; mem_we = 0;
        for (int t = 0; t < 6; t++) begin
            n = 0;
            while (!(if_done || mem_done) && n < 10) begin
                step();
                n++;
            end
            chk($sformatf("streak wait %0d", t), 32'(n < 10), 32'd1);
            seen = {if_done, mem_done};
            chk($sformatf("streak owner %0d", t), 32'(seen), (t == 4) ? 32'd2 : 32'd1);
            step();
            chk($sformatf("streak pulse width %0d", t), 32'({if_done, mem_done}), 32'd0);
        end
        if_req = 0; mem_req = 0;
        step();

        // Reset in the middle of a BUSY load, then a normal load
        mem_req = 1; mem_we = 0; mem_be = 4'hC; mem_addr = 32'h0000_0200; mem_wdata = 32'h5555_0000;
        step();
        #1 chk("rst busy sram_en", 32'(sram_en), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk_bus("rst", 1'b0, 1'b0, 4'h0, 20'h0, 32'h0);
        chk("rst rdata", mem_rdata, 32'h0);
        chk("rst done", 32'({if_done, mem_done}), 32'd0);
        step();
        #1 chk_bus("post rst busy", 1'b1, 1'b0, 4'hC, 20'h80, 32'h5555_0000);
        chk("post rst no done", 32'(mem_done), 32'd0);
        step();
        sram_rdata = 32'h5A5A_0001;
        step();
        #1 chk("post rst mem_done", 32'(mem_done), 32'd1);
        chk("post rst mem_rdata", mem_rdata, 32'h5A5A_0001);
        mem_req = 0;
        step();

        // Randomized traffic against a transaction-level model
        ip = 0; mp = 0; ia = 0; ma = 0; mwd = 0; mwe = 0; mbe = 0;
        streak_m = 0; e_addr = 20'h80; e_be = 4'hC; e_wd = 32'h5555_0000; e_rq = 32'h5A5A_0001;
        for (int tx = 0; tx < 300; tx++) begin
            if (!ip && $urandom_range(3) != 0) begin ip = 1; ia = $urandom; end
            if (!mp && $urandom_range(3) != 0) begin
                mp = 1; ma = $urandom; mwe = 1'($urandom_range(1)); mbe = 4'($urandom); mwd = $urandom;
            end
            if_req = ip; if_addr = ia; mem_req = mp; mem_addr = ma; mem_we = mwe; mem_be = mbe;
            mem_wdata = mwd; sram_rdata = $urandom;
            #1;
            chk_bus("rnd idle", 1'b0, 1'b0, e_be, e_addr, e_wd);
            chk("rnd idle done", 32'({if_done, mem_done}), 32'd0);
            chk("rnd idle stall", 32'({stall_if, stall_mem}), 32'({ip, mp}));
            chk("rnd idle rdata", mem_rdata, e_rq);
            if (mp && !(ip && streak_m == SMAX)) win = 2;
            else if (ip) win = 1;
            else win = 0;
            if (win == 0) begin
                step();
                continue;
            end
            if (win == 2) begin
                streak_m = ip ? ((streak_m < SMAX) ? streak_m + 1 : SMAX) : 0;
                e_addr = ma[21:2]; e_be = mbe; e_wd = mwd; gwe = mwe;
            end else begin
                streak_m = 0;
                e_addr = ia[21:2]; e_be = 4'hF; gwe = 1'b0;
            end
            rv = 0;
            for (int k = 1; k <= W; k++) begin
                step();
                rv = $urandom;
                sram_rdata = rv;
                #1;
                chk_bus("rnd busy", 1'b1, gwe, e_be, e_addr, e_wd);
                chk("rnd busy done", 32'({if_done, mem_done}), 32'd0);
            end
            if (!gwe) e_rq = rv;
            step();
            sram_rdata = $urandom;
            #1;
            chk_bus("rnd done", 1'b0, 1'b0, e_be, e_addr, e_wd);
            chk("rnd done pulse", 32'({if_done, mem_done}), (win == 1) ? 32'd2 : 32'd1);
            chk("rnd done rdata", if_rdata, e_rq);
            chk("rnd done stall", 32'({stall_if, stall_mem}), 32'({ip && win != 1, mp && win != 2}));
            if (win == 1) ip = 0;
            else mp = 0;
            step();
        end
        if_req = 0; mem_req = 0;
        step();
        step();

        // WAIT_CYCLES=1: back-to-back MEM loads every 3 cycles
        b_mem_req = 1; b_mem_we = 0;
        for (int k = 0; k < 12; k++) begin
            b_mem_addr   = 32'h1000 + 32'((k / 3 + ((k % 3 == 2) ? 1 : 0)) * 16);
            b_sram_rdata = (k % 3 == 1) ? 32'hB000_0000 + 32'(k / 3) : 32'h0;
            #1;
            chk($sformatf("w1 sram_en %0d", k),   32'(b_sram_en),   32'(k % 3 == 1));
            chk($sformatf("w1 mem_done %0d", k),  32'(b_mem_done),  32'(k % 3 == 2));
            chk($sformatf("w1 stall_mem %0d", k), 32'(b_stall_mem), 32'(k % 3 != 2));
            if (k % 3 == 1) chk($sformatf("w1 addr %0d", k), 32'(b_sram_addr), 32'h400 + 32'((k / 3) * 4));
            if (k % 3 == 2) chk($sformatf("w1 rdata %0d", k), b_mem_rdata, 32'hB000_0000 + 32'(k / 3));
            step();
        end
        b_mem_req = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
